// File: rtl/imm_gen_pipe.sv
// Multi-lane RISC-V immediate generator with a two-entry (main + skid) output buffer.
// Optional feature: define IMM_GEN_ZICSR_EN to decode CSR-immediate (zimm) instructions as fmt 6.
module imm_gen_pipe #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned LANES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES-1:0]        in_lane_vld,
    input  logic [32*LANES-1:0]     in_inst,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES-1:0]        out_lane_vld,
    output logic [XLEN*LANES-1:0]   out_imm,
    output logic [3*LANES-1:0]      out_fmt
);

    localparam int unsigned IW = 32;
    localparam int unsigned FW = 3;

    localparam logic [FW-1:0] FMT_NONE = 3'd0;
    localparam logic [FW-1:0] FMT_I    = 3'd1;
    localparam logic [FW-1:0] FMT_S    = 3'd2;
    localparam logic [FW-1:0] FMT_B    = 3'd3;
    localparam logic [FW-1:0] FMT_U    = 3'd4;
    localparam logic [FW-1:0] FMT_J    = 3'd5;
`ifdef IMM_GEN_ZICSR_EN
    localparam logic [FW-1:0] FMT_CSR  = 3'd6;
`endif

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic                     in_ready_q, in_ready_d;
    logic                     out_valid_q, out_valid_d;
    logic [LANES-1:0]         main_vld_q, main_vld_d, skid_vld_q, skid_vld_d;
    logic [XLEN*LANES-1:0]    main_imm_q, main_imm_d, skid_imm_q, skid_imm_d;
    logic [FW*LANES-1:0]      main_fmt_q, main_fmt_d, skid_fmt_q, skid_fmt_d;

    logic [LANES-1:0][IW-1:0] lane_inst;
    logic [XLEN*LANES-1:0]    dec_imm;
    logic [FW*LANES-1:0]      dec_fmt;
    logic                     in_xfer, out_xfer;
    logic                     unused_lsbs;

    assign lane_inst   = in_inst;
    assign unused_lsbs = ^lane_inst;

    // Per-lane decode; every immediate is built as 32 bits then sign-extended to XLEN.
    always_comb begin
        logic [IW-1:0] imm32;
        logic [FW-1:0] fmt;
        dec_imm = '0;
        dec_fmt = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            imm32 = '0;
            fmt   = FMT_NONE;
            if (in_lane_vld[k]) begin
                case (lane_inst[k][6:2])
                    5'b00000, 5'b00100, 5'b11001: begin
                        fmt   = FMT_I;
                        imm32 = {{20{lane_inst[k][31]}}, lane_inst[k][31:20]};
                    end
                    5'b01000: begin
                        fmt   = FMT_S;
                        imm32 = {{20{lane_inst[k][31]}}, lane_inst[k][31:25], lane_inst[k][11:7]};
                    end
                    5'b11000: begin
                        fmt   = FMT_B;
                        imm32 = {{20{lane_inst[k][31]}}, lane_inst[k][7], lane_inst[k][30:25],
                                 lane_inst[k][11:8], 1'b0};
                    end
                    5'b01101, 5'b00101: begin
                        fmt   = FMT_U;
                        imm32 = {lane_inst[k][31:12], 12'b0};
                    end
                    5'b11011: begin
                        fmt   = FMT_J;
                        imm32 = {{12{lane_inst[k][31]}}, lane_inst[k][19:12], lane_inst[k][20],
                                 lane_inst[k][30:21], 1'b0};
                    end
`ifdef IMM_GEN_ZICSR_EN
                    5'b11100: begin
                        if (lane_inst[k][14]) begin
                            fmt   = FMT_CSR;
                            imm32 = {27'b0, lane_inst[k][19:15]};
                        end
                    end
`endif
                    default: begin
                        fmt   = FMT_NONE;
                        imm32 = '0;
                    end
                endcase
            end
            dec_imm[XLEN*k +: XLEN] = XLEN'($signed(imm32));
            dec_fmt[FW*k +: FW]     = fmt;
        end
    end

    assign in_xfer  = in_valid && in_ready_q;
    assign out_xfer = out_valid_q && out_ready;

    // Buffer control: flush overrides every transfer; skid drains into main.
    always_comb begin
        state_d    = state_q;
        main_vld_d = main_vld_q;
        main_imm_d = main_imm_q;
        main_fmt_d = main_fmt_q;
        skid_vld_d = skid_vld_q;
        skid_imm_d = skid_imm_q;
        skid_fmt_d = skid_fmt_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_xfer) begin
                        main_vld_d = in_lane_vld;
                        main_imm_d = dec_imm;
                        main_fmt_d = dec_fmt;
                        state_d    = ONE;
                    end
                end
                ONE: begin
                    if (in_xfer && !out_xfer) begin
                        skid_vld_d = in_lane_vld;
                        skid_imm_d = dec_imm;
                        skid_fmt_d = dec_fmt;
                        state_d    = TWO;
                    end else if (in_xfer && out_xfer) begin
                        main_vld_d = in_lane_vld;
                        main_imm_d = dec_imm;
                        main_fmt_d = dec_fmt;
                    end else if (out_xfer) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (out_xfer) begin
                        main_vld_d = skid_vld_q;
                        main_imm_d = skid_imm_q;
                        main_fmt_d = skid_fmt_q;
                        state_d    = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
        in_ready_d  = (state_d != TWO);
        out_valid_d = (state_d != EMPTY);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            main_vld_q  <= '0;
            main_imm_q  <= '0;
            main_fmt_q  <= '0;
            skid_vld_q  <= '0;
            skid_imm_q  <= '0;
            skid_fmt_q  <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            main_vld_q  <= main_vld_d;
            main_imm_q  <= main_imm_d;
            main_fmt_q  <= main_fmt_d;
            skid_vld_q  <= skid_vld_d;
            skid_imm_q  <= skid_imm_d;
            skid_fmt_q  <= skid_fmt_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign out_valid    = out_valid_q;
    assign out_lane_vld = main_vld_q;
    assign out_imm      = main_imm_q;
    assign out_fmt      = main_fmt_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: XLEN=64 and XLEN=32 instances share one 2-lane stimulus stream.
// Expected beats are queued on acceptance and compared while they sit at the output.
module tb_imm_gen_pipe;

    typedef struct packed {
        logic [1:0]       lv;
        logic [1:0][63:0] imm;
        logic [1:0][2:0]  fmt;
    } beat_t;

    logic          clk;
    logic          rst, flush, in_valid, out_ready;
    logic [1:0]    in_lane_vld;
    logic [63:0]   in_inst;

    logic          r64_in_ready, r64_out_valid;
    logic [1:0]    r64_lv;
    logic [127:0]  r64_imm;
    logic [5:0]    r64_fmt;
    logic          r32_in_ready, r32_out_valid;
    logic [1:0]    r32_lv;
    logic [63:0]   r32_imm;
    logic [5:0]    r32_fmt;

    int            n_checks = 0;
    int            n_fail   = 0;
    logic          started  = 1'b0;
    beat_t         sb[$];

    imm_gen_pipe #(.XLEN(64), .LANES(2)) dut64 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(r64_in_ready),
        .in_lane_vld(in_lane_vld), .in_inst(in_inst), .out_valid(r64_out_valid),
        .out_ready(out_ready), .out_lane_vld(r64_lv), .out_imm(r64_imm), .out_fmt(r64_fmt)
    );

    imm_gen_pipe #(.XLEN(32), .LANES(2)) dut32 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(r32_in_ready),
        .in_lane_vld(in_lane_vld), .in_inst(in_inst), .out_valid(r32_out_valid),
        .out_ready(out_ready), .out_lane_vld(r32_lv), .out_imm(r32_imm), .out_fmt(r32_fmt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] ref_imm(input logic [31:0] x, input logic v, output logic [2:0] f);
        logic [63:0] r;
        logic        s;
        s = x[31];
        r = '0;
        f = 3'd0;
        if (v) begin
            case (x[6:2])
                5'h00, 5'h04, 5'h19: begin f = 3'd1; r = {{52{s}}, x[31:20]}; end
                5'h08: begin f = 3'd2; r = {{52{s}}, x[31:25], x[11:7]}; end
                5'h18: begin f = 3'd3; r = {{52{s}}, x[7], x[30:25], x[11:8], 1'b0}; end
                5'h0D, 5'h05: begin f = 3'd4; r = {{32{s}}, x[31:12], 12'h000}; end
                5'h1B: begin f = 3'd5; r = {{44{s}}, x[19:12], x[20], x[30:21], 1'b0}; end
`ifdef IMM_GEN_ZICSR_EN
                5'h1C: if (x[14]) begin f = 3'd6; r = {59'd0, x[19:15]}; end
`endif
                default: begin f = 3'd0; r = '0; end
            endcase
        end
        return r;
    endfunction

    function automatic beat_t model_beat(input logic [1:0] lv, input logic [63:0] inst);
        beat_t       b;
        logic [2:0]  f;
        b.lv = lv;
        for (int k = 0; k < 2; k++) begin
            b.imm[k] = ref_imm(inst[32*k +: 32], lv[k], f);
            b.fmt[k] = f;
        end
        return b;
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [4:0]  ops [10];
        logic [31:0] x;
        ops = '{5'h00, 5'h04, 5'h19, 5'h08, 5'h18, 5'h0D, 5'h05, 5'h1B, 5'h1C, 5'h0C};
        x      = $urandom;
        x[6:2] = ops[$urandom_range(0, 9)];
        x[1:0] = 2'b11;
        return x;
    endfunction

    // One cycle: drive at negedge, check against scoreboard, let the posedge happen.
    task automatic cycle(input logic v, input logic [1:0] lv, input logic [63:0] inst,
                         input logic ordy, input logic fl, input logic rs, output logic acc);
        beat_t e;
        in_valid    = v;
        in_lane_vld = lv;
        in_inst     = inst;
        out_ready   = ordy;
        flush       = fl;
        rst         = rs;
        #1;
        acc = 1'b0;
        if (started && !rs) begin
            check_eq("in_ready_vs_model", 64'(r64_in_ready), 64'(sb.size() < 2));
            check_eq("out_valid_vs_model", 64'(r64_out_valid), 64'(sb.size() != 0));
            check_eq("in_ready_32_vs_64", 64'(r32_in_ready), 64'(r64_in_ready));
            check_eq("out_valid_32_vs_64", 64'(r32_out_valid), 64'(r64_out_valid));
        end
        if (rs || fl) begin
            sb.delete();
        end else begin
            if (r64_out_valid && sb.size() != 0) begin
                e = sb[0];
                check_eq("lane_vld", 64'(r64_lv), 64'(e.lv));
                check_eq("lane_vld_32", 64'(r32_lv), 64'(e.lv));
                for (int k = 0; k < 2; k++) begin
                    check_eq("imm64", r64_imm[64*k +: 64], e.imm[k]);
                    check_eq("fmt64", 64'(r64_fmt[3*k +: 3]), 64'(e.fmt[k]));
                    check_eq("imm32", 64'(r32_imm[32*k +: 32]), 64'(e.imm[k][31:0]));
                    check_eq("fmt32", 64'(r32_fmt[3*k +: 3]), 64'(e.fmt[k]));
                end
                if (ordy) void'(sb.pop_front());
            end
            if (v && r64_in_ready) begin
                sb.push_back(model_beat(lv, inst));
                acc = 1'b1;
            end
        end
        if (rs) started = 1'b1;
        @(negedge clk);
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_out_valid"}, 64'(r64_out_valid), 64'd0);
        check_eq({tag, "_in_ready"}, 64'(r64_in_ready), 64'd1);
        check_eq({tag, "_lane_vld"}, 64'(r64_lv), 64'd0);
        check_eq({tag, "_imm_lo"}, r64_imm[63:0], 64'd0);
        check_eq({tag, "_imm_hi"}, r64_imm[127:64], 64'd0);
        check_eq({tag, "_fmt"}, 64'(r64_fmt), 64'd0);
        check_eq({tag, "_imm32"}, r32_imm, 64'd0);
    endtask

    initial begin
        logic        a;
        logic        pend;
        logic [63:0] pi;
        logic [1:0]  plv;
        logic        fl;
        logic [63:0] csr_imm;
        logic [2:0]  csr_fmt;
`ifdef IMM_GEN_ZICSR_EN
        csr_imm = 64'h1F;
        csr_fmt = 3'd6;
`else
        csr_imm = 64'h0;
        csr_fmt = 3'd0;
`endif
        @(negedge clk);
        cycle(1'b0, 2'b00, 64'd0, 1'b1, 1'b0, 1'b1, a);
        cycle(1'b0, 2'b00, 64'd0, 1'b1, 1'b0, 1'b1, a);
        check_reset_values("reset");

        // addi -1 / sw 12, one cycle latency
        cycle(1'b1, 2'b11, {32'h00112623, 32'hFFF00093}, 1'b1, 1'b0, 1'b0, a);
        check_eq("addi_valid", 64'(r32_out_valid), 64'd1);
        check_eq("addi_imm32", 64'(r32_imm[31:0]), 64'hFFFFFFFF);
        check_eq("addi_fmt", 64'(r32_fmt[2:0]), 64'd1);
        check_eq("sw_imm32", 64'(r32_imm[63:32]), 64'h0000000C);
        check_eq("sw_fmt", 64'(r32_fmt[5:3]), 64'd2);

        // beq -4 / jal -8 at XLEN=64
        cycle(1'b1, 2'b11, {32'hFF9FF06F, 32'hFE000EE3}, 1'b1, 1'b0, 1'b0, a);
        check_eq("beq_imm64", r64_imm[63:0], 64'hFFFFFFFFFFFFFFFC);
        check_eq("beq_fmt", 64'(r64_fmt[2:0]), 64'd3);
        check_eq("jal_imm64", r64_imm[127:64], 64'hFFFFFFFFFFFFFFF8);
        check_eq("jal_fmt", 64'(r64_fmt[5:3]), 64'd5);

        // lui plus a masked lane
        cycle(1'b1, 2'b01, {32'h300FD073, 32'h123452B7}, 1'b1, 1'b0, 1'b0, a);
        check_eq("lui_imm64", r64_imm[63:0], 64'h0000000012345000);
        check_eq("lui_fmt", 64'(r64_fmt[2:0]), 64'd4);
        check_eq("masked_imm", r64_imm[127:64], 64'd0);
        check_eq("masked_fmt", 64'(r64_fmt[5:3]), 64'd0);

        // csrrwi zimm 31
        cycle(1'b1, 2'b11, {32'h300FD073, 32'h300FD073}, 1'b1, 1'b0, 1'b0, a);
        check_eq("csr_imm", r64_imm[63:0], csr_imm);
        check_eq("csr_fmt", 64'(r64_fmt[2:0]), 64'(csr_fmt));
        cycle(1'b0, 2'b00, 64'd0, 1'b1, 1'b0, 1'b0, a);

        // Backpressure: A, B fill the buffer, C waits
        cycle(1'b1, 2'b11, {32'h00500093, 32'h00A00113}, 1'b0, 1'b0, 1'b0, a);
        cycle(1'b1, 2'b10, {32'h000010B7, 32'hFE1FF0EF}, 1'b0, 1'b0, 1'b0, a);
        check_eq("full_in_ready", 64'(r64_in_ready), 64'd0);
        cycle(1'b1, 2'b11, {32'hFE112E23, 32'h00008067}, 1'b0, 1'b0, 1'b0, a);
        check_eq("stall_c_accepted", 64'(a), 64'd0);
        check_eq("stall_out_valid", 64'(r64_out_valid), 64'd1);
        for (int i = 0; i < 4 && !a; i++)
            cycle(1'b1, 2'b11, {32'hFE112E23, 32'h00008067}, 1'b1, 1'b0, 1'b0, a);
        check_eq("c_accepted", 64'(a), 64'd1);
        for (int i = 0; i < 4; i++) cycle(1'b0, 2'b00, 64'd0, 1'b1, 1'b0, 1'b0, a);

        // Flush from TWO with a beat presented
        cycle(1'b1, 2'b11, {32'h00500093, 32'h00A00113}, 1'b0, 1'b0, 1'b0, a);
        cycle(1'b1, 2'b11, {32'h000010B7, 32'hFE1FF0EF}, 1'b0, 1'b0, 1'b0, a);
        cycle(1'b1, 2'b11, {32'h7FF00093, 32'h80000537}, 1'b1, 1'b1, 1'b0, a);
        check_eq("flush_out_valid", 64'(r64_out_valid), 64'd0);
        check_eq("flush_in_ready", 64'(r64_in_ready), 64'd1);
        for (int i = 0; i < 3; i++) cycle(1'b0, 2'b00, 64'd0, 1'b1, 1'b0, 1'b0, a);

        // Reset from TWO
        cycle(1'b1, 2'b11, {32'h00500093, 32'h00A00113}, 1'b0, 1'b0, 1'b0, a);
        cycle(1'b1, 2'b11, {32'h000010B7, 32'hFE1FF0EF}, 1'b0, 1'b0, 1'b0, a);
        cycle(1'b1, 2'b11, {32'h7FF00093, 32'h80000537}, 1'b1, 1'b1, 1'b1, a);
        check_reset_values("midrst");

        // Random traffic with random backpressure and occasional flush
        pend = 1'b0;
        pi   = '0;
        plv  = '0;
        for (int i = 0; i < 400; i++) begin
            if (!pend && $urandom_range(0, 2) != 0) begin
                pend = 1'b1;
                pi   = {rand_inst(), rand_inst()};
                plv  = 2'($urandom_range(0, 3));
            end
            fl = ($urandom_range(0, 39) == 0);
            cycle(pend, plv, pi, 1'($urandom_range(0, 1)), fl, 1'b0, a);
            if (a || fl) pend = 1'b0;
        end

        for (int i = 0; i < 10 && sb.size() != 0; i++)
            cycle(1'b0, 2'b00, 64'd0, 1'b1, 1'b0, 1'b0, a);
        check_eq("drain_empty", 64'(sb.size()), 64'd0);
        check_eq("drain_out_valid", 64'(r64_out_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/imm_gen_pipe.md
IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, immediate output width (32 or 64); sign-extension fills bits XLEN-1 down to the source sign bit.
REQ-002 SHALL have parameter LANES, default 2, instructions per beat (1..4).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port flush  input  1  discards all buffered and incoming beats.
REQ-006 SHALL have port in_valid  input  1  upstream beat valid.
REQ-007 SHALL have port in_ready  output  1  block can accept a beat this cycle.
REQ-008 SHALL have port in_lane_vld  input  LANES  per-lane instruction valid mask.
REQ-009 SHALL have port in_inst  input  32*LANES  lane k at bits [32k+31:32k].
REQ-010 SHALL have port out_valid  output  1  output beat valid.
REQ-011 SHALL have port out_ready  input  1  downstream accepts output beat.
REQ-012 SHALL have port out_lane_vld  output  LANES  registered copy of in_lane_vld.
REQ-013 SHALL have port out_imm  output  XLEN*LANES  per-lane immediate.
REQ-014 SHALL have port out_fmt  output  3*LANES  per-lane format: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 CSR.

Function
REQ-015 SHALL decode by inst[6:2]: 00000/00100/11001 -> I; 01000 -> S; 11000 -> B; 01101/00101 -> U; 11011 -> J; all others -> NONE, imm 0.
REQ-016 SHALL form: I {sx,inst[31:20]}; S {sx,inst[31:25],inst[11:7]}; B {sx,inst[7],inst[30:25],inst[11:8],0}; U {sx,inst[31:12],12'b0}; J {sx,inst[19:12],inst[20],inst[30:21],0}; sx = inst[31] replicated to XLEN.
REQ-017 SHALL force imm 0 and fmt NONE for any lane with in_lane_vld[k]=0.
REQ-018 SHALL have a 2-entry output buffer (main + skid) with states EMPTY, ONE, TWO.
REQ-019 Transfer in: in_valid && in_ready; transfer out: out_valid && out_ready.
REQ-020 Latency: beat accepted at edge N SHALL appear on out_* after edge N (one cycle) when buffer was EMPTY or draining.
REQ-021 in_ready SHALL be registered: 1 in EMPTY and ONE, 0 in TWO; never combinationally dependent on out_ready.
REQ-022 Transitions: EMPTY+in -> ONE; ONE+in+!out -> TWO; ONE+out+!in -> EMPTY; ONE+in+out -> ONE; TWO+out -> ONE (skid moves to main); all other cases hold state.
REQ-023 Output order SHALL equal acceptance order; out_* SHALL be stable while out_valid && !out_ready.
REQ-024 out_valid SHALL be 1 exactly in ONE and TWO.
REQ-025 flush SHALL go to EMPTY at next edge and drop any beat presented the same cycle; flush wins over every simultaneous transfer.
REQ-026 Lanes SHALL decode independently; no cross-lane dependence.

Reset
REQ-027 On rst at clock edge: state EMPTY, out_valid 0, in_ready 1, out_lane_vld 0, out_imm 0, out_fmt 0.
REQ-028 rst mid-operation SHALL discard both buffer entries; rst has priority over flush and transfers.

Configuration
REQ-029 Macro IMM_GEN_ZICSR_EN: when defined, inst[6:2]=11100 with inst[14]=1 SHALL give fmt CSR, imm = zero-extended inst[19:15]; when undefined, opcode 11100 SHALL give fmt NONE, imm 0, and code 6 never appears.

Verification
REQ-030 XLEN=32, lane0 0xFFF00093 (addi -1), lane1 0x00112623 (sw 12) -> next cycle out_imm0 0xFFFFFFFF fmt 1, out_imm1 0x0000000C fmt 2.
REQ-031 XLEN=64, 0xFE000EE3 (beq -4) -> 0xFFFFFFFFFFFFFFFC fmt 3; 0xFF9FF06F (jal -8) -> 0xFFFFFFFFFFFFFFF8 fmt 5; 0x123452B7 (lui) -> 0x0000000012345000 fmt 4.
REQ-032 out_ready=0, in_valid=1 with beats A,B,C -> A,B accepted, in_ready 0 from cycle after B; out_ready=1 -> A,B then C emitted in order, no loss or duplicate.
REQ-033 Buffer TWO, flush=1 with in_valid=1 -> next cycle out_valid 0, in_ready 1; dropped beat never appears.
REQ-034 0x300FD073 (csrrwi zimm 31): with IMM_GEN_ZICSR_EN -> imm 0x1F fmt 6; without -> imm 0 fmt 0; in_lane_vld=2'b01 -> lane1 imm 0 fmt 0.
REQ-035 rst asserted in state TWO -> next cycle all outputs at REQ-027 values.
